// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default widths, data/accumulator types, saturation
// limits, the fc FSM state type and a field-offset helper for packed vectors.
package cnn_pkg;

    localparam int DEF_I_WIDTH   = 16;
    localparam int DEF_FRAC_BITS = 8;
    localparam int DEF_CHANNELS  = 5;
    localparam int DEF_ACC_WIDTH = 40;

    typedef logic signed [DEF_I_WIDTH-1:0]   data_t;
    typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

    // Largest / smallest representable data word at the default width
    localparam data_t SAT_MAX = {1'b0, {(DEF_I_WIDTH-1){1'b1}}};
    localparam data_t SAT_MIN = {1'b1, {(DEF_I_WIDTH-1){1'b0}}};

    typedef enum logic {
        FC_IDLE  = 1'b0,
        FC_ACCUM = 1'b1
    } fc_state_e;

    // Low bit of field idx in a vector of equal-width fields
    function automatic int field_lo(int idx, int width);
        return idx * width;
    endfunction

    // Saturation limits for an arbitrary word width
    function automatic longint sat_hi(int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fc_layer_if.sv
// Pixel/result bus for fc_layer plus the weight-row write port used to fill
// the per-pixel weight table before the first frame.
interface fc_layer_if #(
    parameter int I_WIDTH    = 16,
    parameter int CHANNELS   = 5,
    parameter int OUTPUTS    = 4,
    parameter int NUM_PIXELS = 49
);
    localparam int PW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int ROW_W = OUTPUTS * CHANNELS * I_WIDTH;

    logic [CHANNELS*I_WIDTH-1:0] input_data;
    logic                        input_valid;
    logic [OUTPUTS*I_WIDTH-1:0]  output_data;
    logic                        valid;
    logic                        w_we;
    logic [PW-1:0]               w_addr;
    logic [ROW_W-1:0]            w_data;

    modport master (
        output input_data, input_valid, w_we, w_addr, w_data,
        input  output_data, valid
    );

    modport slave (
        input  input_data, input_valid, w_we, w_addr, w_data,
        output output_data, valid
    );
endinterface

// File: rtl/fc_mac_lane.sv
// One neuron of the fully-connected stage: CHANNELS multipliers, sum, frame
// accumulator and final rescale/format. Define FC_SATURATE_EN to clamp the
// result to the data range instead of wrapping.
module fc_mac_lane
    import cnn_pkg::*;
#(
    parameter int I_WIDTH   = DEF_I_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        s1_valid,
    input  logic                        s1_last,
    input  logic [CHANNELS*I_WIDTH-1:0] x,
    input  logic [CHANNELS*I_WIDTH-1:0] w,
    output logic [I_WIDTH-1:0]          res
);
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_sum;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic        [I_WIDTH-1:0]   res_nxt;

    // Sum of full-precision channel products, sign-extended to the accumulator
    always_comb begin
        logic [I_WIDTH-1:0]          xv, wv;
        logic signed [2*I_WIDTH-1:0] xs, ws, p;
        prod_sum = '0;
        xv = '0; wv = '0; xs = '0; ws = '0; p = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            xv = x[field_lo(c, I_WIDTH) +: I_WIDTH];
            wv = w[field_lo(c, I_WIDTH) +: I_WIDTH];
            xs = {{I_WIDTH{xv[I_WIDTH-1]}}, xv};
            ws = {{I_WIDTH{wv[I_WIDTH-1]}}, wv};
            p  = xs * ws;
            prod_sum = prod_sum + {{(ACC_WIDTH-2*I_WIDTH){p[2*I_WIDTH-1]}}, p};
        end
    end

    assign acc_nxt = acc + prod_sum;

`ifdef FC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] R_MAX = ACC_WIDTH'(sat_hi(I_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] R_MIN = ACC_WIDTH'(sat_lo(I_WIDTH));
    logic signed [ACC_WIDTH-1:0] r;

    // Rescale to the data format and clamp into range
    always_comb begin
        r = acc_nxt >>> FRAC_BITS;
        if (r > R_MAX)
            res_nxt = R_MAX[I_WIDTH-1:0];
        else if (r < R_MIN)
            res_nxt = R_MIN[I_WIDTH-1:0];
        else
            res_nxt = r[I_WIDTH-1:0];
    end
`else
    // Arithmetic shift then keep the low word: a plain field pick
    assign res_nxt = acc_nxt[FRAC_BITS +: I_WIDTH];
`endif

    // Accumulate every pixel; on the last one publish and restart from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            res <= '0;
        end else if (clk_en && s1_valid) begin
            if (s1_last) begin
                res <= res_nxt;
                acc <= '0;
            end else begin
                acc <= acc_nxt;
            end
        end
    end
endmodule

// File: rtl/fc_layer.sv
// Fully-connected output stage: samples pooled pixels, looks up the weight
// row for the pixel position, and feeds OUTPUTS MAC lanes. One valid pulse
// per frame of NUM_PIXELS pixels. Optional macro FC_SATURATE_EN selects
// clamping (defined) or wrapping (undefined) of each result.
module fc_layer
    import cnn_pkg::*;
#(
    parameter int I_WIDTH    = DEF_I_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int NUM_PIXELS = 49,
    parameter int OUTPUTS    = 4,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clk_en,
    fc_layer_if.slave bus
);
    localparam int PW     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int LANE_W = CHANNELS * I_WIDTH;
    localparam int ROW_W  = OUTPUTS * LANE_W;
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);

    logic [ROW_W-1:0]  w_rom [NUM_PIXELS];
    logic [PW-1:0]     pix_cnt;
    logic              pix_last;
    logic              s1_valid;
    logic              s1_last;
    logic [LANE_W-1:0] s1_x;
    logic [ROW_W-1:0]  s1_w;
    logic              valid_q;
    fc_state_e         state;
    logic [OUTPUTS-1:0][I_WIDTH-1:0] lane_res;

    assign pix_last = (pix_cnt == LAST_PIX);

    // Weight table fill; independent of clk_en so it can be loaded any time
    always_ff @(posedge clk) begin
        if (bus.w_we)
            w_rom[bus.w_addr] <= bus.w_data;
    end

    // Stage-1 control: pixel position counter and pipeline valid/last flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (clk_en) begin
            s1_valid <= bus.input_valid;
            if (bus.input_valid) begin
                s1_last <= pix_last;
                pix_cnt <= pix_last ? '0 : pix_cnt + PW'(1);
            end
        end
    end

    // Stage-1 data: pixel register and synchronous weight-row read
    always_ff @(posedge clk) begin
        if (clk_en && bus.input_valid) begin
            s1_x <= bus.input_data;
            s1_w <= w_rom[pix_cnt];
        end
    end

    // Frame tracking: idle between frames, accumulating inside one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FC_IDLE;
        end else if (clk_en && bus.input_valid) begin
            case (state)
                FC_IDLE:  state <= pix_last ? FC_IDLE : FC_ACCUM;
                FC_ACCUM: if (pix_last) state <= FC_IDLE;
                default:  state <= FC_IDLE;
            endcase
        end
    end

    // Result strobe: one enabled cycle after the last pixel reaches stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= 1'b0;
        else if (clk_en)
            valid_q <= s1_valid && s1_last;
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_lane
        fc_mac_lane #(
            .I_WIDTH   (I_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .CHANNELS  (CHANNELS),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clk_en   (clk_en),
            .s1_valid (s1_valid),
            .s1_last  (s1_last),
            .x        (s1_x),
            .w        (s1_w[o*LANE_W +: LANE_W]),
            .res      (lane_res[o])
        );
    end

    assign bus.output_data = lane_res;
    assign bus.valid       = valid_q;

    // Between frames the pixel position is always back at zero
    a_idle_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == FC_IDLE) |-> (pix_cnt == '0));
endmodule
